hyperbus_delay_calib: RTL and testbench

HYPERBUS_DELAY_CALIB -- requirements
Module: hyperbus_delay_calib

---
 rtl/hyperbus_delay_calib_if.sv | 31 +++
 rtl/hyperbus_delay_calib.sv | 101 ++++++++++
 tb/tb_hyperbus_delay_calib.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hyperbus_delay_calib_if.sv
// hyperbus_delay_calib_if: control, status and trial handshake bundle for the delay calibrator.
// Debug observation signals exist only when HYPERBUS_DELAY_CALIB_DEBUG_EN is defined.
interface hyperbus_delay_calib_if;
  logic       start_i;
  logic       busy_o;
  logic       done_o;
  logic       error_o;
  logic [3:0] delay_o;
  logic       trial_req_o;
  logic       trial_ack_i;
  logic       trial_pass_i;
`ifdef HYPERBUS_DELAY_CALIB_DEBUG_EN
  logic [15:0] pass_map_o;
  logic [3:0]  win_start_o;
  logic [4:0]  win_len_o;
`endif
  modport master (
    input  start_i, trial_ack_i, trial_pass_i,
    output busy_o, done_o, error_o, delay_o, trial_req_o
`ifdef HYPERBUS_DELAY_CALIB_DEBUG_EN
    , output pass_map_o, win_start_o, win_len_o
`endif
  );
  modport slave (
    output start_i, trial_ack_i, trial_pass_i,
    input  busy_o, done_o, error_o, delay_o, trial_req_o
`ifdef HYPERBUS_DELAY_CALIB_DEBUG_EN
    , input pass_map_o, win_start_o, win_len_o
`endif
  );
endinterface

// File: rtl/hyperbus_delay_calib.sv
// hyperbus_delay_calib: sweeps 16 delay taps, finds the longest passing window and parks on its centre.
// Define HYPERBUS_DELAY_CALIB_DEBUG_EN to expose the pass map and best window.
module hyperbus_delay_calib #(
  parameter int         SettleCycles = 8,
  parameter logic [3:0] DefaultDelay = 4'd8
) (
  input logic clk_i,
  input logic rst_i,
  hyperbus_delay_calib_if.master bus
);
  localparam int CW = SettleCycles > 1 ? $clog2(SettleCycles) : 1;
  typedef enum logic [2:0] {IDLE, SETTLE, TRIAL, EVAL, FINISH} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0] tap, run_start, run_start_n, best_start, best_start_n, half, result, delay_q;
  logic [4:0] run_len, run_len_n, best_len, best_len_n;
  logic pass_q, grow, error_q;
`ifdef HYPERBUS_DELAY_CALIB_DEBUG_EN
  logic [15:0] pass_map;
`endif
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start_i ? SETTLE : IDLE;
      SETTLE:  state_n = cnt == CW'(SettleCycles - 1) ? TRIAL : SETTLE;
      TRIAL:   state_n = bus.trial_ack_i ? EVAL : TRIAL;
      EVAL:    state_n = tap == 4'd15 ? FINISH : SETTLE;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // A run only wins when strictly longer, so the earliest of equal windows is kept.
  always_comb begin
    run_len_n    = pass_q ? run_len + 5'd1 : 5'd0;
    run_start_n  = (pass_q && run_len == 5'd0) ? tap : run_start;
    grow         = pass_q && run_len_n > best_len;
    best_len_n   = grow ? run_len_n : best_len;
    best_start_n = grow ? run_start_n : best_start;
    half         = 4'((best_len_n - 5'd1) >> 1);
    result       = best_start_n + half;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt        <= '0;
      tap        <= '0;
      run_len    <= '0;
      run_start  <= '0;
      best_len   <= '0;
      best_start <= '0;
      pass_q     <= 1'b0;
      delay_q    <= DefaultDelay;
      error_q    <= 1'b0;
`ifdef HYPERBUS_DELAY_CALIB_DEBUG_EN
      pass_map   <= '0;
`endif
    end else begin
      cnt <= state == SETTLE ? cnt + 1'b1 : '0;
      if (state == IDLE && bus.start_i) begin
        tap        <= '0;
        run_len    <= '0;
        run_start  <= '0;
        best_len   <= '0;
        best_start <= '0;
        error_q    <= 1'b0;
`ifdef HYPERBUS_DELAY_CALIB_DEBUG_EN
        pass_map   <= '0;
`endif
      end
      if (state == TRIAL && bus.trial_ack_i) begin
        pass_q <= bus.trial_pass_i;
`ifdef HYPERBUS_DELAY_CALIB_DEBUG_EN
        pass_map[tap] <= bus.trial_pass_i;
`endif
      end
      if (state == EVAL) begin
        run_len    <= run_len_n;
        run_start  <= run_start_n;
        best_len   <= best_len_n;
        best_start <= best_start_n;
        if (tap != 4'd15) tap <= tap + 4'd1;
        else begin
          delay_q <= best_len_n == 5'd0 ? DefaultDelay : result;
          error_q <= best_len_n == 5'd0;
        end
      end
    end
  end
  assign bus.busy_o      = state != IDLE;
  assign bus.done_o      = state == FINISH;
  assign bus.trial_req_o = state == TRIAL;
  assign bus.error_o     = error_q;
  assign bus.delay_o     = (state == SETTLE || state == TRIAL || state == EVAL) ? tap : delay_q;
`ifdef HYPERBUS_DELAY_CALIB_DEBUG_EN
  assign bus.pass_map_o  = pass_map;
  assign bus.win_start_o = best_start;
  assign bus.win_len_o   = best_len;
`endif
endmodule

// File: tb/tb_hyperbus_delay_calib.sv
// tb_hyperbus_delay_calib: directed sweeps with a pattern-driven trial responder and hand-computed results.
module tb_hyperbus_delay_calib;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  hyperbus_delay_calib_if bus();
  hyperbus_delay_calib #(.SettleCycles(8), .DefaultDelay(4'd8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );
  int total = 0;
  int bad = 0;
  logic [15:0] pattern = '0;
  int ack_delay = 0;
  int cycles, dones, max_req;
  logic moved;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Trial responder: acks after ack_delay waiting cycles, passing per pattern bit at the current tap.
  initial begin
    int w;
    w = 0;
    bus.trial_ack_i = 1'b0;
    bus.trial_pass_i = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.trial_req_o) begin
        if (w >= ack_delay) begin
          bus.trial_ack_i = 1'b1;
          bus.trial_pass_i = pattern[bus.delay_o];
        end else w++;
      end else begin
        bus.trial_ack_i = 1'b0;
        bus.trial_pass_i = 1'b0;
        w = 0;
      end
    end
  end
  task automatic run_sweep(input logic [15:0] pat, input int dly, input logic mid_start);
    int cur, extra;
    logic prev_req;
    logic [3:0] prev_d;
    pattern = pat;
    ack_delay = dly;
    cycles = -1;
    dones = 0;
    max_req = 0;
    moved = 1'b0;
    cur = 0;
    extra = 0;
    prev_req = 1'b0;
    prev_d = '0;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int i = 1; i <= 2000 && extra < 5; i++) begin
      @(posedge clk);
      #1;
      if (mid_start) bus.start_i = (i == 50);
      if (bus.done_o) begin
        dones++;
        if (cycles < 0) cycles = i;
      end
      if (bus.trial_req_o) begin
        cur++;
        if (prev_req && bus.delay_o !== prev_d) moved = 1'b1;
      end else cur = 0;
      if (cur > max_req) max_req = cur;
      prev_req = bus.trial_req_o;
      prev_d = bus.delay_o;
      if (cycles >= 0) extra++;
    end
  endtask
  initial begin
    logic found;
    rst = 1'b1;
    bus.start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_error", bus.error_o, 0);
    check("rst_delay", bus.delay_o, 8);
    check("rst_req", bus.trial_req_o, 0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(16'h0FE0, 0, 1'b0);
    check("w5_11_cycles", cycles, 160);
    check("w5_11_delay", bus.delay_o, 8);
    check("w5_11_error", bus.error_o, 0);
    check("w5_11_dones", dones, 1);
    check("w5_11_req_len", max_req, 1);
    check("w5_11_idle", bus.busy_o, 0);
    run_sweep(16'h0000, 0, 1'b0);
    check("none_delay", bus.delay_o, 8);
    check("none_error", bus.error_o, 1);
    check("none_dones", dones, 1);
    run_sweep(16'h0E1C, 0, 1'b0);
    check("tie_delay", bus.delay_o, 3);
    check("tie_error", bus.error_o, 0);
    run_sweep(16'hF000, 0, 1'b0);
    check("top_delay", bus.delay_o, 13);
    repeat (10) @(posedge clk);
    #1;
    check("idle_hold_delay", bus.delay_o, 13);
    check("idle_hold_error", bus.error_o, 0);
    run_sweep(16'hFFFF, 0, 1'b0);
    check("all_delay", bus.delay_o, 7);
    run_sweep(16'h0FE0, 5, 1'b0);
    check("slow_req_len", max_req, 6);
    check("slow_moved", moved, 0);
    check("slow_delay", bus.delay_o, 8);
    check("slow_error", bus.error_o, 0);
    check("slow_cycles", cycles, 240);
    run_sweep(16'hFFFF, 0, 1'b1);
    check("mid_start_dones", dones, 1);
    check("mid_start_cycles", cycles, 160);
    check("mid_start_delay", bus.delay_o, 7);
    pattern = 16'h0FE0;
    ack_delay = 0;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(posedge clk);
      #1;
      found = bus.busy_o && bus.delay_o == 4'd6;
    end
    check("reach_tap6", found, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_delay", bus.delay_o, 8);
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_req", bus.trial_req_o, 0);
    check("midrst_done", bus.done_o, 0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(16'h0FE0, 0, 1'b0);
    check("recover_cycles", cycles, 160);
    check("recover_delay", bus.delay_o, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
